// File: rtl/prog_loader.sv
// Instruction-memory loader: packs a byte stream MSB-first into 32-bit words, writes them,
// zero-fills the remaining entries, then raises cpu_run_o. PROG_LOADER_CHECKSUM_EN adds a trailing XOR check byte.
module prog_loader #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              s_valid_i,
  input  logic [7:0]        s_data_i,
  output logic              s_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  output logic              busy_o,
  output logic              cpu_run_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
`ifdef PROG_LOADER_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_FILL,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [ADDR_W:0] DepthWords = (ADDR_W+1)'(DEPTH);
  localparam logic [7:0]      DepthByte  = 8'(DEPTH);

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic                memWe_q, memWe_d;
  logic [ADDR_W-1:0]   memAddr_q, memAddr_d;
  logic [WORD_W-1:0]   memWdata_q, memWdata_d;
  logic                busy_q, busy_d;
  logic                cpuRun_q, cpuRun_d;
  logic                err_q, err_d;
  logic [1:0]          byteCnt_q, byteCnt_d;
  logic [ADDR_W:0]     wordCnt_q, wordCnt_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [WORD_W-9:0]   shift_q, shift_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic accept;
  assign accept = s_valid_i && ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      busy_q     <= 1'b0;
      cpuRun_q   <= 1'b0;
      err_q      <= 1'b0;
      byteCnt_q  <= '0;
      wordCnt_q  <= '0;
      count_q    <= '0;
      shift_q    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      busy_q     <= busy_d;
      cpuRun_q   <= cpuRun_d;
      err_q      <= err_d;
      byteCnt_q  <= byteCnt_d;
      wordCnt_q  <= wordCnt_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // wordCnt_q doubles as the fill pointer; it holds N when DATA finishes and DEPTH when FILL finishes.
  always_comb begin
    state_d    = state_q;
    memWe_d    = 1'b0;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    byteCnt_d  = byteCnt_q;
    wordCnt_d  = wordCnt_q;
    count_d    = count_q;
    shift_d    = shift_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_HDR;
      end
      ST_HDR: begin
        if (accept) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d = s_data_i;
`endif
          if ((s_data_i == 8'd0) || (s_data_i > DepthByte)) begin
            state_d = ST_ERR;
          end else begin
            count_d   = s_data_i[ADDR_W:0];
            wordCnt_d = '0;
            byteCnt_d = '0;
            state_d   = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (wordCnt_q == count_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = ST_CSUM;
`else
          state_d = ST_FILL;
`endif
        end else if (accept) begin
          shift_d   = {shift_q[WORD_W-17:0], s_data_i};
          byteCnt_d = byteCnt_q + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d    = csum_q ^ s_data_i;
`endif
          if (byteCnt_q == 2'd3) begin
            memWe_d    = 1'b1;
            memAddr_d  = wordCnt_q[ADDR_W-1:0];
            memWdata_d = {shift_q, s_data_i};
            wordCnt_d  = wordCnt_q + (ADDR_W+1)'(1);
          end
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (accept) state_d = (s_data_i == csum_q) ? ST_FILL : ST_ERR;
      end
`endif
      ST_FILL: begin
        if (wordCnt_q == DepthWords) begin
          state_d = ST_DONE;
        end else begin
          memWe_d    = 1'b1;
          memAddr_d  = wordCnt_q[ADDR_W-1:0];
          memWdata_d = '0;
          wordCnt_d  = wordCnt_q + (ADDR_W+1)'(1);
        end
      end
      ST_DONE, ST_ERR: begin
        if (start_i) state_d = ST_HDR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they change on the same edge as the state.
  always_comb begin
    ready_d  = (state_d == ST_HDR) ||
               ((state_d == ST_DATA) && (wordCnt_d != count_d));
`ifdef PROG_LOADER_CHECKSUM_EN
    if (state_d == ST_CSUM) ready_d = 1'b1;
`endif
    busy_d   = (state_d != ST_IDLE) && (state_d != ST_DONE) && (state_d != ST_ERR);
    cpuRun_d = (state_d == ST_DONE);
    err_d    = (state_d == ST_ERR);
  end

  assign s_ready_o   = ready_q;
  assign mem_we_o    = memWe_q;
  assign mem_addr_o  = memAddr_q;
  assign mem_wdata_o = memWdata_q;
  assign busy_o      = busy_q;
  assign cpu_run_o   = cpuRun_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of whole-load vectors plus directed multi-cycle sequences.
module tb_prog_loader;

   localparam int WORD_W = 32;
   localparam int DEPTH  = 32;
   localparam int ADDR_W = 5;

   logic              clk;
   logic              rst;
   logic              start;
   logic              sValid;
   logic [7:0]        sData;
   logic              s_ready_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [WORD_W-1:0] mem_wdata_o;
   logic              busy_o;
   logic              cpu_run_o;
   logic              err_o;

   int checks = 0;
   int failures = 0;
   int cycleCnt = 0;
   int lastAcceptCycle = 0;
   logic [7:0]        csumRun;
   logic [31:0]       payload [DEPTH];
   logic [31:0]       mem [DEPTH];
   logic [ADDR_W-1:0] wrAddr[$];
   logic [31:0]       wrData[$];

   typedef struct {
      logic [7:0]  hdr;
      logic [31:0] w0;
      logic [31:0] w1;
      int          nWords;
      bit          expErr;
      int          expWrites;
      int          expLatency;
   } vec_t;

   vec_t vecs [5];

   prog_loader #(.WORD_W(WORD_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start),
      .s_valid_i  (sValid),
      .s_data_i   (sData),
      .s_ready_o  (s_ready_o),
      .mem_we_o   (mem_we_o),
      .mem_addr_o (mem_addr_o),
      .mem_wdata_o(mem_wdata_o),
      .busy_o     (busy_o),
      .cpu_run_o  (cpu_run_o),
      .err_o      (err_o)
   );

   // Free-running clock and an edge counter used for latency measurements
   always #5 clk = ~clk;
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Memory model and write log, sampled mid-cycle while the strobe is stable
   always @(negedge clk) begin
      if (mem_we_o) begin
         mem[mem_addr_o] = mem_wdata_o;
         wrAddr.push_back(mem_addr_o);
         wrData.push_back(mem_wdata_o);
      end
   end

   // One comparison: bump the counters and report a miss
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // One-cycle start pulse, issued #1 after an edge
   task automatic pulseStart();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Offer a byte and return #1 after the edge that accepts it; sValid is left high
   task automatic sendByte(input logic [7:0] b);
      int guard;
      guard = 0;
      sValid = 1'b1;
      sData = b;
      while (!s_ready_o && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!s_ready_o) begin
         checks++;
         failures++;
         $display("[TB] FAIL byte accept timeout actual=s_ready low required=high");
      end
      @(posedge clk); #1;
      lastAcceptCycle = cycleCnt;
   endtask

   // Stream payload words MSB first; optional random gaps and an ignored mid-load start
   task automatic streamWords(input int n, input bit gaps);
      logic [7:0] b;
      for (int w = 0; w < n; w++) begin
         for (int k = 0; k < 4; k++) begin
            b = payload[w][31-8*k -: 8];
            if (gaps && ($urandom_range(0, 2) == 0)) begin
               sValid = 1'b0;
               repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
            end
            if (gaps && w == 12 && k == 2) begin
               sValid = 1'b0;
               pulseStart();
            end
            sendByte(b);
            csumRun = csumRun ^ b;
            if (k == 3) begin
               checkOutput("word strobe", {31'b0, mem_we_o}, 32'd1);
               checkOutput("word addr", {27'b0, mem_addr_o}, 32'(w));
               checkOutput("word data", mem_wdata_o, payload[w]);
            end
         end
      end
   endtask

   // Wait for DONE or ERR within a cycle budget
   task automatic waitEnd(output int doneCycle);
      int guard;
      guard = 0;
      while (!cpu_run_o && !err_o && guard < 300) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!cpu_run_o && !err_o) begin
         checks++;
         failures++;
         $display("[TB] FAIL end-of-load timeout actual=no cpu_run/err required=one of them");
      end
      doneCycle = cycleCnt;
   endtask

   // Logged writes must be words 0..nWords-1 then zeros, at ascending addresses from 0
   task automatic checkWrites(input int nWords, input int expTotal, input string tag);
      int bad;
      logic [31:0] ed;
      bad = 0;
      checkOutput({tag, " write count"}, wrAddr.size(), expTotal);
      for (int i = 0; i < wrAddr.size() && i < expTotal; i++) begin
         ed = (i < nWords) ? payload[i] : 32'h0;
         if (wrAddr[i] != i[ADDR_W-1:0] || wrData[i] != ed) bad++;
      end
      checkOutput({tag, " write order/data"}, bad, 0);
   endtask

   // Header plus payload (plus check byte when enabled) for one table vector
   task automatic runBody(input vec_t v, input string tag);
      int doneCycle;
      wrAddr.delete();
      wrData.delete();
      payload[0] = v.w0;
      payload[1] = v.w1;
      sendByte(v.hdr);
      csumRun = v.hdr;
      if (v.nWords == 0) begin
         sValid = 1'b0;
         checkOutput({tag, " err"}, {31'b0, err_o}, {31'b0, v.expErr});
         checkOutput({tag, " busy"}, {31'b0, busy_o}, 32'd0);
         repeat (3) begin @(posedge clk); #1; end
         checkOutput({tag, " cpu_run"}, {31'b0, cpu_run_o}, 32'd0);
         checkWrites(0, v.expWrites, tag);
      end else begin
         streamWords(v.nWords, 1'b0);
`ifdef PROG_LOADER_CHECKSUM_EN
         sendByte(csumRun);
`endif
         sValid = 1'b0;
         waitEnd(doneCycle);
         checkOutput({tag, " err"}, {31'b0, err_o}, {31'b0, v.expErr});
         checkOutput({tag, " cpu_run"}, {31'b0, cpu_run_o}, {31'b0, ~v.expErr});
         checkOutput({tag, " busy"}, {31'b0, busy_o}, 32'd0);
`ifndef PROG_LOADER_CHECKSUM_EN
         checkOutput({tag, " done latency"}, doneCycle - lastAcceptCycle, v.expLatency);
`endif
         checkWrites(v.nWords, v.expWrites, tag);
      end
   endtask

   task automatic applyStimulus(input vec_t v, input string tag);
      pulseStart();
      runBody(v, tag);
   endtask

   initial begin
      int doneCycle;
      int nonZero;
      vec_t v;

      clk = 1'b0;
      rst = 1'b1;
      start = 1'b0;
      sValid = 1'b0;
      sData = 8'h00;
      csumRun = 8'h00;

      vecs[0] = '{8'd2,   32'h02000A01, 32'h04030102, 2, 1'b0, 32, 32};
      vecs[1] = '{8'd0,   32'h0,        32'h0,        0, 1'b1, 0,  0};
      vecs[2] = '{8'd33,  32'h0,        32'h0,        0, 1'b1, 0,  0};
      vecs[3] = '{8'd1,   32'hDEADBEEF, 32'h0,        1, 1'b0, 32, 33};
      vecs[4] = '{8'hFF,  32'h0,        32'h0,        0, 1'b1, 0,  0};

      // Reset state
      #1;
      checkOutput("reset s_ready", {31'b0, s_ready_o}, 32'd0);
      checkOutput("reset busy", {31'b0, busy_o}, 32'd0);
      checkOutput("reset cpu_run", {31'b0, cpu_run_o}, 32'd0);
      checkOutput("reset err", {31'b0, err_o}, 32'd0);
      checkOutput("reset mem_we", {31'b0, mem_we_o}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Bytes offered in IDLE are not taken
      sValid = 1'b1;
      sData = 8'h01;
      repeat (3) begin @(posedge clk); #1; end
      checkOutput("idle s_ready", {31'b0, s_ready_o}, 32'd0);
      checkOutput("idle busy", {31'b0, busy_o}, 32'd0);
      sValid = 1'b0;

      for (int i = 0; i < 5; i++) begin
         $display("[TB] vector %0d header=%0d", i, vecs[i].hdr);
         applyStimulus(vecs[i], $sformatf("vec%0d", i));
      end

      // Full 32-word load with random valid gaps and an ignored start in DATA
      $display("[TB] full-depth load with gaps");
      for (int i = 0; i < DEPTH; i++)
         for (int k = 0; k < 4; k++)
            payload[i][31-8*k -: 8] = 8'(((i*4 + k) * 7 + 3));
      wrAddr.delete();
      wrData.delete();
      pulseStart();
      sendByte(8'd32);
      csumRun = 8'd32;
      streamWords(DEPTH, 1'b1);
`ifdef PROG_LOADER_CHECKSUM_EN
      sendByte(csumRun);
`endif
      sValid = 1'b0;
      waitEnd(doneCycle);
      checkOutput("full cpu_run", {31'b0, cpu_run_o}, 32'd1);
`ifndef PROG_LOADER_CHECKSUM_EN
      checkOutput("full done latency", doneCycle - lastAcceptCycle, 2);
`endif
      checkWrites(DEPTH, DEPTH, "full");

      // Restart from DONE, then reload one word over the full image
      pulseStart();
      checkOutput("restart cpu_run", {31'b0, cpu_run_o}, 32'd0);
      checkOutput("restart busy", {31'b0, busy_o}, 32'd1);
      checkOutput("restart err", {31'b0, err_o}, 32'd0);
      v = '{8'd1, 32'h08180000, 32'h0, 1, 1'b0, 32, 33};
      runBody(v, "reload");
      checkOutput("reload mem0", mem[0], 32'h08180000);
      nonZero = 0;
      for (int i = 1; i < DEPTH; i++) if (mem[i] != 32'h0) nonZero++;
      checkOutput("reload fill cleared", nonZero, 0);

      // Asynchronous reset in the middle of DATA
      $display("[TB] reset during payload");
      payload[0] = 32'h11223344;
      payload[1] = 32'h55667788;
      pulseStart();
      sendByte(8'd2);
      for (int k = 0; k < 6; k++) sendByte(payload[k/4][31-8*(k%4) -: 8]);
      sValid = 1'b0;
      checkOutput("pre-reset busy", {31'b0, busy_o}, 32'd1);
      #2 rst = 1'b1;
      #1;
      checkOutput("async reset s_ready", {31'b0, s_ready_o}, 32'd0);
      checkOutput("async reset busy", {31'b0, busy_o}, 32'd0);
      checkOutput("async reset mem_we", {31'b0, mem_we_o}, 32'd0);
      checkOutput("async reset mem_addr", {27'b0, mem_addr_o}, 32'd0);
      checkOutput("async reset mem_wdata", mem_wdata_o, 32'd0);
      checkOutput("async reset cpu_run", {31'b0, cpu_run_o}, 32'd0);
      checkOutput("async reset err", {31'b0, err_o}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      v = '{8'd1, 32'h01000000, 32'h0, 1, 1'b0, 32, 33};
      applyStimulus(v, "post-reset");
      checkOutput("post-reset mem0", mem[0], 32'h01000000);

`ifdef PROG_LOADER_CHECKSUM_EN
      // Correct and wrong trailing check bytes for header 1, word 01 02 03 04
      payload[0] = 32'h01020304;
      wrAddr.delete();
      wrData.delete();
      pulseStart();
      sendByte(8'd1);
      streamWords(1, 1'b0);
      sendByte(8'h05);
      sValid = 1'b0;
      waitEnd(doneCycle);
      checkOutput("csum good cpu_run", {31'b0, cpu_run_o}, 32'd1);
      checkOutput("csum good err", {31'b0, err_o}, 32'd0);
      checkWrites(1, DEPTH, "csum good");

      wrAddr.delete();
      wrData.delete();
      pulseStart();
      sendByte(8'd1);
      streamWords(1, 1'b0);
      sendByte(8'h06);
      sValid = 1'b0;
      waitEnd(doneCycle);
      checkOutput("csum bad err", {31'b0, err_o}, 32'd1);
      checkOutput("csum bad cpu_run", {31'b0, cpu_run_o}, 32'd0);
      repeat (3) begin @(posedge clk); #1; end
      checkWrites(1, 1, "csum bad");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
